// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the iterative divider (div_iter_unit).
//   div_state_t : FSM states IDLE -> PREP -> CALC -> FIX -> DONE
//   HILO_*      : HI/LO write-enable encodings driven while a divide is in EX
//   abs_w       : two's-complement magnitude of a zero-extended value
// -----------------------------------------------------------------------------
package div_pkg;

  // Widest operand abs_w can handle; div_iter_unit WIDTH must not exceed it.
  localparam int DIV_MAX_W = 64;

  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_PREP = 3'd1;
  localparam logic [2:0] ENC_CALC = 3'd2;
  localparam logic [2:0] ENC_FIX  = 3'd3;
  localparam logic [2:0] ENC_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ENC_IDLE,
    PREP = ENC_PREP,
    CALC = ENC_CALC,
    FIX  = ENC_FIX,
    DONE = ENC_DONE
  } div_state_t;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_BOTH = 2'b11;

  // Magnitude of a value held in the low bits of val (upper bits zero).
  // The caller truncates the result back to its own width, so the most
  // negative number maps onto its own bit pattern, read as unsigned.
  function automatic logic [DIV_MAX_W-1:0] abs_w(input logic [DIV_MAX_W-1:0] val,
                                                 input logic              is_neg);
    return is_neg ? -val : val;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// Combinational slice of a restoring divider: STEP chained shift/compare/
// subtract stages, retiring STEP quotient bits (MSB first).
//   i_rem   [WIDTH:0]   partial remainder entering the slice
//   i_bits  [STEP-1:0]  next dividend bits, MSB first
//   i_dvs   [WIDTH-1:0] divisor magnitude
//   o_rem   [WIDTH:0]   partial remainder leaving the slice
//   o_qbits [STEP-1:0]  quotient bits produced, MSB first
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [STEP-1:0]  i_bits,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic [STEP-1:0]  o_qbits
);

  logic [WIDTH:0] w_r;
  logic [WIDTH:0] w_trial;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through the block leaves one unassigned and no latch is inferred.
    w_r     = i_rem;
    w_trial = '0;
    o_qbits = '0;
    // NOTE: blocking assignments chain the stages within one evaluation;
    // each stage reads the remainder the previous stage just produced.
    for (int k = STEP - 1; k >= 0; k--) begin
      // Remainder stays below the divisor, so bit WIDTH-1 is the top live bit.
      w_trial = {w_r[WIDTH-1:0], i_bits[k]};
      if (w_trial >= {1'b0, i_dvs}) begin
        w_r        = w_trial - {1'b0, i_dvs};
        o_qbits[k] = 1'b1;
      end else begin
        w_r = w_trial;
      end
    end
    o_rem = w_r;
  end

endmodule

// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
// Multi-cycle DIV/DIVU unit for the EX stage. Restoring division, STEP
// quotient bits per CALC cycle; quotient goes to LO, remainder to HI.
// Also produces the pipeline stall and the HI/LO write enables.
//
// Parameters: WIDTH (even, >= 8), STEP (1, 2 or 4, divides WIDTH).
// Optional:   define DIV_EARLY_EXIT_EN to skip CALC when the divisor is zero
//             or |dividend| < |divisor| (result then in 3 cycles).
//
// Ports:
//   clk, resetn           clock; synchronous active-low reset
//   valid_i               EX holds a DIV/DIVU
//   signed_i              1 = DIV, 0 = DIVU (sampled at accept)
//   dividend_i/divisor_i  operands (sampled at accept)
//   annul_i               flush of EX; kills the operation in flight
//   hilo_we_i             HI/LO enables from decode for non-divide ops
//   stall_o               valid_i & ~ready_o
//   ready_o               one-cycle result-valid pulse (DONE)
//   quotient_o            registered quotient
//   remainder_o           registered remainder
//   hilo_we_o             valid_i ? (ready_o ? 11 : 00) : hilo_we_i
// -----------------------------------------------------------------------------
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  input  logic [1:0]       hilo_we_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [1:0]       hilo_we_o
);

  localparam int N_ITER = WIDTH / STEP;
  localparam int CNT_W  = $clog2(N_ITER + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 8 || WIDTH > DIV_MAX_W ||
      !(STEP == 1 || STEP == 2 || STEP == 4) || (WIDTH % STEP) != 0) begin : g_param_err
    $error("div_iter_unit: illegal WIDTH/STEP combination");
  end

  div_state_t       r_state;
  div_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;

  // Operands as accepted, kept raw for the divide-by-zero remainder.
  logic             r_signed;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;

  // Working registers: r_quo starts as |dividend| and shifts into the quotient.
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_step_rem;
  logic [STEP-1:0]  w_step_q;

  assign w_accept  = (r_state == IDLE) & valid_i & ~annul_i;
  assign w_abs_dvd = WIDTH'(abs_w(DIV_MAX_W'(r_dividend), r_signed & r_dividend[WIDTH-1]));
  assign w_abs_dvs = WIDTH'(abs_w(DIV_MAX_W'(r_divisor),  r_signed & r_divisor[WIDTH-1]));

`ifdef DIV_EARLY_EXIT_EN
  logic w_early;
  assign w_early = (r_divisor == '0) | (w_abs_dvd < w_abs_dvs);
`endif

  div_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_rem   (r_rem),
    .i_bits  (r_quo[WIDTH-1 -: STEP]),
    .i_dvs   (r_dvs),
    .o_rem   (w_step_rem),
    .o_qbits (w_step_q)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = PREP;
`ifdef DIV_EARLY_EXIT_EN
      PREP: w_next = w_early ? FIX : CALC;
`else
      PREP: w_next = CALC;
`endif
      CALC: if (r_cnt == CNT_W'(1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // A flush wins over everything, including a same-cycle accept.
    if (annul_i) w_next = IDLE;
  end

  // -------------------------------------------- counter and result registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        PREP:    r_cnt <= CNT_W'(N_ITER);
        CALC:    r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      // Results survive annul; a flushed op never overwrites them.
      if (r_state == FIX && !annul_i) begin
        if (r_div_zero) begin
          r_quotient  <= '1;
          r_remainder <= r_dividend;
        end else begin
          r_quotient  <= r_neg_q ? -r_quo : r_quo;
          r_remainder <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        end
      end
    end
  end

  // ------------------------------------------------------------ datapath
  // NOTE: datapath registers carry no reset; each is loaded in IDLE/PREP
  // before anything reads it, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          r_signed   <= signed_i;
          r_dividend <= dividend_i;
          r_divisor  <= divisor_i;
        end
      end
      PREP: begin
        r_quo      <= w_abs_dvd;
        r_rem      <= '0;
        r_dvs      <= w_abs_dvs;
        r_neg_q    <= r_signed & (r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1]);
        r_neg_r    <= r_signed & r_dividend[WIDTH-1];
        r_div_zero <= (r_divisor == '0);
`ifdef DIV_EARLY_EXIT_EN
        // Skipped CALC: quotient 0, remainder is the dividend magnitude.
        if (w_early) begin
          r_quo <= '0;
          r_rem <= {1'b0, w_abs_dvd};
        end
`endif
      end
      CALC: begin
        r_rem <= w_step_rem;
        r_quo <= {r_quo[WIDTH-STEP-1:0], w_step_q};
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------- outputs
  assign ready_o     = (r_state == DONE);
  assign stall_o     = valid_i & ~ready_o;
  assign hilo_we_o   = valid_i ? (ready_o ? HILO_BOTH : HILO_NONE) : hilo_we_i;
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;

endmodule

// File: tb/tb_div_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_div_iter_unit
// Two divider instances (STEP=1 and STEP=2, WIDTH=32) share stimulus; sel
// chooses which one receives valid and whose outputs are observed.
// Expected values come from plain 64-bit integer division of the operands.
// Honours DIV_EARLY_EXIT_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_div_iter_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         valid;
  logic         sel;
  logic         signed_in;
  logic [W-1:0] dvd;
  logic [W-1:0] dvs;
  logic         annul;
  logic [1:0]   hilo_in;

  logic         stall1, ready1, stall2, ready2;
  logic [W-1:0] q1, r1, q2, r2;
  logic [1:0]   we1, we2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk         (clk),
    .resetn      (resetn),
    .valid_i     (valid & ~sel),
    .signed_i    (signed_in),
    .dividend_i  (dvd),
    .divisor_i   (dvs),
    .annul_i     (annul),
    .hilo_we_i   (hilo_in),
    .stall_o     (stall1),
    .ready_o     (ready1),
    .quotient_o  (q1),
    .remainder_o (r1),
    .hilo_we_o   (we1)
  );

  div_iter_unit #(.WIDTH(W), .STEP(2)) u_dut2 (
    .clk         (clk),
    .resetn      (resetn),
    .valid_i     (valid & sel),
    .signed_i    (signed_in),
    .dividend_i  (dvd),
    .divisor_i   (dvs),
    .annul_i     (annul),
    .hilo_we_i   (hilo_in),
    .stall_o     (stall2),
    .ready_o     (ready2),
    .quotient_o  (q2),
    .remainder_o (r2),
    .hilo_we_o   (we2)
  );

  wire          obs_ready = sel ? ready2 : ready1;
  wire          obs_stall = sel ? stall2 : stall1;
  wire [W-1:0]  obs_q     = sel ? q2 : q1;
  wire [W-1:0]  obs_r     = sel ? r2 : r1;
  wire [1:0]    obs_we    = sel ? we2 : we1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer division on 64-bit values, truncating toward zero.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output bit early);
    longint sa, sb, aa, ab;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    aa = (sa < 0) ? -sa : sa;
    ab = (sb < 0) ? -sb : sb;
    early = (b == 0) || (aa < ab);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Issue one op starting just after a falling edge. annul_at >= 0 flushes
  // it in that cycle and returns in the following cycle.
  task automatic run_op(input bit use2, input bit s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag, input int annul_at);
    logic [W-1:0] eq, er;
    bit early, seen;
    int n, lat, cyc, bad_stall, bad_we;
    model(a, b, s, eq, er, early);
    n = use2 ? W / 2 : W;
`ifdef DIV_EARLY_EXIT_EN
    lat = early ? 3 : n + 3;
`else
    lat = n + 3;
`endif
    sel = use2; signed_in = s; dvd = a; dvs = b; hilo_in = 2'b10; valid = 1'b1;
    seen = 0; bad_stall = 0; bad_we = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (obs_ready) begin
        seen = 1;
        break;
      end
      if (obs_stall !== 1'b1) bad_stall++;
      if (obs_we !== 2'b00)   bad_we++;
      if (cyc == annul_at) begin
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        check({tag, "/stall_before_annul"}, bad_stall, 0);
        return;
      end
      @(negedge clk);
    end
    check({tag, "/latency"}, seen ? cyc : -1, lat);
    check({tag, "/stall_while_busy"}, bad_stall, 0);
    check({tag, "/we_while_busy"}, bad_we, 0);
    if (seen) begin
      check({tag, "/quotient"}, obs_q, eq);
      check({tag, "/remainder"}, obs_r, er);
      check({tag, "/we_done"}, obs_we, 2'b11);
      check({tag, "/stall_done"}, obs_stall, 1'b0);
    end
    @(negedge clk);
    valid = 1'b0;
    hilo_in = 2'b01;
    #1;
    check({tag, "/ready_one_cycle"}, obs_ready, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; valid = 1'b0; sel = 1'b0; signed_in = 1'b0;
    dvd = '0; dvs = '0; annul = 1'b0; hilo_in = 2'b00;

    // Reset state; stall follows valid even while reset is held.
    repeat (3) @(negedge clk);
    valid = 1'b1;
    #1;
    check("reset/ready1", ready1, 1'b0);
    check("reset/q1", q1, 32'h0);
    check("reset/r1", r1, 32'h0);
    check("reset/ready2", ready2, 1'b0);
    check("reset/q2", q2, 32'h0);
    check("reset/stall_in_reset", stall1, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    resetn = 1'b1;

    // Directed cases.
    run_op(0, 0, 32'd100, 32'd7, "divu_100_7", -1);
    run_op(0, 1, -32'sd7, 32'd2, "div_m7_2", -1);
    run_op(0, 1, 32'd7, -32'sd2, "div_7_m2", -1);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", -1);
    run_op(0, 0, 32'h1234, 32'h0, "divu_by_zero", -1);
    run_op(0, 1, -32'sd5, 32'h0, "div_neg_by_zero", -1);

    // Flush mid-op, then the next op must start from IDLE right away.
    run_op(0, 0, 32'd50, 32'd5, "annul_50_5", 10);
    run_op(0, 0, 32'd9, 32'd4, "after_annul", -1);

    // Non-divide HI/LO pass-through.
    sel = 1'b0; valid = 1'b0; hilo_in = 2'b01;
    #1;
    check("pass/we_01", we1, 2'b01);
    check("pass/stall", stall1, 1'b0);
    hilo_in = 2'b10;
    #1;
    check("pass/we_10", we1, 2'b10);
    @(negedge clk);

    run_op(1, 0, 32'hFFFF_FFFF, 32'd3, "step2_divu", -1);
    run_op(0, 0, 32'd5, 32'd9, "divu_5_9", -1);
    run_op(1, 1, -32'sd3, 32'd5, "step2_div_small", -1);

    // Reset in the middle of an op clears results and returns to IDLE.
    sel = 1'b0; signed_in = 1'b0; dvd = 32'd100; dvs = 32'd7; valid = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    valid = 1'b0;
    #1;
    check("midreset/ready", ready1, 1'b0);
    check("midreset/q", q1, 32'h0);
    check("midreset/r", r1, 32'h0);
    @(negedge clk);
    run_op(0, 0, 32'd1000, 32'd33, "after_midreset", -1);

    // Randomised ops across both instances, mixing operand magnitudes.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a, b;
      bit s;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        2: b = $urandom | 32'h8000_0000;
        default: begin
          a = $urandom_range(0, 100);
          b = $urandom_range(1, 200);
        end
      endcase
      run_op(1'(i % 2), s, a, b, $sformatf("rand%0d", i), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
